// File: rtl/dm_write_buffer.sv
// Store buffer and req/ack memory adapter behind the core's single-cycle DM port.
// Optional WB_COALESCE_EN: stores to an already-buffered, not-in-flight address merge in place.
module dm_write_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     core_enable,
    input  logic                     core_read,
    input  logic                     core_write,
    input  logic [ADDR_WIDTH-1:0]    core_address,
    input  logic [DATA_WIDTH-1:0]    core_wdata,
    output logic [DATA_WIDTH-1:0]    core_rdata,
    output logic                     core_stall,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_WIDTH-1:0]    mem_address,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    input  logic                     mem_ack,
    output logic [$clog2(DEPTH):0]   buf_count,
    output logic                     buf_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        LOAD,
        LD_DONE
    } state_t;

    state_t                 state;
    state_t                 next_state;

    logic [DEPTH-1:0]       valid;
    logic [ADDR_WIDTH-1:0]  addr_q [DEPTH];
    logic [DATA_WIDTH-1:0]  data_q [DEPTH];
    logic [PTR_W-1:0]       head;
    logic [PTR_W-1:0]       tail;
    logic [CNT_W-1:0]       count;
    logic [DATA_WIDTH-1:0]  rd_q;

    logic                   store_req;
    logic                   load_req;
    logic                   full;
    logic                   hit;
    logic                   miss;
    logic                   co_hit;
    logic                   enq;
    logic                   pop;
    logic                   ack_fire;
    logic                   issue_load;
    logic                   issue_drain;
    logic [PTR_W-1:0]       co_idx;
    logic [PTR_W-1:0]       scan_f;
    logic [DATA_WIDTH-1:0]  fwd_data;
    logic [DATA_WIDTH-1:0]  drain_data;

    // A store with read also high is a store; the read is dropped.
    assign store_req = core_enable & core_write;
    assign load_req  = core_enable & core_read & ~core_write;
    assign full      = (count == FULL_COUNT);
    assign miss      = load_req & ~hit;
    assign ack_fire  = mem_ack & mem_req;
    assign pop       = (state == DRAIN) & ack_fire;
    assign enq       = store_req & ~co_hit & ~full;

    // Scan oldest to youngest so the last match left standing is the youngest store.
    // NOTE: always_comb uses blocking assignments, with every output defaulted first so no latch is inferred.
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        scan_f   = head;
        for (int i = 0; i < DEPTH; i++) begin
            scan_f = head + PTR_W'(i);
            if (valid[scan_f] && addr_q[scan_f] == core_address) begin
                hit      = 1'b1;
                fwd_data = data_q[scan_f];
            end
        end
    end

`ifdef WB_COALESCE_EN
    logic [PTR_W-1:0] scan_c;

    // The head is off limits only while its write is on the bus.
    always_comb begin
        co_hit = 1'b0;
        co_idx = '0;
        scan_c = head;
        for (int i = 0; i < DEPTH; i++) begin
            scan_c = head + PTR_W'(i);
            if (store_req && valid[scan_c] && addr_q[scan_c] == core_address &&
                !(state == DRAIN && scan_c == head)) begin
                co_hit = 1'b1;
                co_idx = scan_c;
            end
        end
    end
`else
    assign co_hit = 1'b0;
    assign co_idx = '0;
`endif

    // A merge into the head on the cycle its drain launches must reach the bus.
    assign drain_data = (co_hit && co_idx == head) ? core_wdata : data_q[head];

    always_comb begin
        next_state  = state;
        issue_load  = 1'b0;
        issue_drain = 1'b0;
        unique case (state)
            IDLE: begin
                if (miss) begin
                    next_state = LOAD;
                    issue_load = 1'b1;
                end else if (count != '0) begin
                    next_state  = DRAIN;
                    issue_drain = 1'b1;
                end
            end
            DRAIN:   if (ack_fire) next_state = IDLE;
            LOAD:    if (ack_fire) next_state = LD_DONE;
            LD_DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        core_stall = 1'b0;
        core_rdata = rd_q;
        if (!rst) begin
            core_stall = (store_req & ~co_hit & full) | (miss & (state != LD_DONE));
        end
        if (load_req && hit) begin
            core_rdata = fwd_data;
        end
    end

    assign buf_count = count;
    assign buf_empty = (count == '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + PTR_W'(1);
            end
            if (enq) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PTR_W'(1);
            end
            if (enq && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !enq) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // NOTE: the payload arrays carry no reset; the valid bits alone decide what is live.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail] <= core_address;
            data_q[tail] <= core_wdata;
        end else if (co_hit) begin
            data_q[co_idx] <= core_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            rd_q        <= '0;
        end else begin
            if (issue_load) begin
                mem_req     <= 1'b1;
                mem_we      <= 1'b0;
                mem_address <= core_address;
            end else if (issue_drain) begin
                mem_req     <= 1'b1;
                mem_we      <= 1'b1;
                mem_address <= addr_q[head];
                mem_wdata   <= drain_data;
            end else if (ack_fire) begin
                mem_req <= 1'b0;
            end

            if (state == LOAD && ack_fire) begin
                rd_q <= mem_rdata;
            end else if (load_req && hit) begin
                rd_q <= fwd_data;
            end
        end
    end

endmodule
